branch_predictor: RTL

Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters; consumes the branch_buffer_types_pkg types (buffer_t, pc_t; tag 28, index 2, pad 2).

---
 rtl/branch_predictor.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// The fetch stage looks it up combinationally. The resolve stage updates one
// entry per cycle. Branch and mispredict statistics counters are kept beside it.

package branch_buffer_types_pkg;
  localparam int TAG_W = 28;
  localparam int IND_W = 2;
  localparam int PAD_W = 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IND_W-1:0] idx;
    logic [PAD_W-1:0] pad;
  } pc_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } buffer_t;
endpackage

module branch_predictor
  import branch_buffer_types_pkg::*;
#(
  parameter int         IND_W     = 2,
  parameter logic [1:0] INIT_CNT  = 2'b01,
  parameter logic [1:0] ALLOC_CNT = 2'b10,
  parameter int         STAT_W    = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       fetch_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic              pred_hit,
  input  logic              upd_en,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int NUM_ENT = 2 ** IND_W;

  buffer_t     buf_q [NUM_ENT];
  buffer_t     buf_d [NUM_ENT];
  logic [1:0]  cnt_q [NUM_ENT];
  logic [1:0]  cnt_d [NUM_ENT];
  logic [STAT_W-1:0] branch_q, branch_d;
  logic [STAT_W-1:0] mispred_q, mispred_d;

  pc_t     fetch_s;
  pc_t     upd_s;
  buffer_t fetch_ent_s;
  buffer_t upd_ent_s;
  logic    upd_hit_s;
  logic    mispredict_s;
  logic    unused_pad_s;

  assign fetch_s      = pc_t'(fetch_pc);
  assign upd_s        = pc_t'(upd_pc);
  // Byte-offset bits never take part in the lookup.
  assign unused_pad_s = ^{fetch_s.pad, upd_s.pad};

  // Lookup reads pre-update state only; an update on this edge shows up next cycle.
  always_comb begin
    fetch_ent_s = buf_q[fetch_s.idx];
    pred_hit    = fetch_ent_s.valid && (fetch_ent_s.tag == fetch_s.tag);
    pred_taken  = pred_hit && cnt_q[fetch_s.idx][1];
    if (pred_taken) begin
      pred_target = fetch_ent_s.target;
    end else begin
      pred_target = fetch_pc + 32'd4;
    end
  end

  // Mispredict: wrong direction, or correctly taken but to the wrong target.
  always_comb begin
    mispredict_s = upd_en && ((upd_pred_taken != upd_taken) ||
                   (upd_taken && upd_pred_taken && (upd_pred_target != upd_target)));
  end

  // Next-state for the buffer entries and direction counters.
  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) begin
      buf_d[i] = buf_q[i];
      cnt_d[i] = cnt_q[i];
    end
    upd_ent_s = buf_q[upd_s.idx];
    upd_hit_s = upd_ent_s.valid && (upd_ent_s.tag == upd_s.tag);
    if (upd_en) begin
      if (upd_hit_s && upd_taken) begin
        buf_d[upd_s.idx].target = upd_target;
        if (cnt_q[upd_s.idx] != 2'b11) begin
          cnt_d[upd_s.idx] = cnt_q[upd_s.idx] + 2'd1;
        end else begin
          cnt_d[upd_s.idx] = 2'b11;
        end
      end else if (upd_hit_s) begin
        if (cnt_q[upd_s.idx] != 2'b00) begin
          cnt_d[upd_s.idx] = cnt_q[upd_s.idx] - 2'd1;
        end else begin
          cnt_d[upd_s.idx] = 2'b00;
        end
      end else if (upd_taken) begin
        buf_d[upd_s.idx].valid  = 1'b1;
        buf_d[upd_s.idx].tag    = upd_s.tag;
        buf_d[upd_s.idx].target = upd_target;
        cnt_d[upd_s.idx]        = ALLOC_CNT;
      end else begin
        cnt_d[upd_s.idx] = cnt_q[upd_s.idx];
      end
    end else begin
      cnt_d[upd_s.idx] = cnt_q[upd_s.idx];
    end
  end

  // Statistics next-state; both counters wrap silently.
  always_comb begin
    if (upd_en) begin
      branch_d = branch_q + STAT_W'(1);
    end else begin
      branch_d = branch_q;
    end
    if (mispredict_s) begin
      mispred_d = mispred_q + STAT_W'(1);
    end else begin
      mispred_d = mispred_q;
    end
  end

  // State registers; async reset discards any update pending on the edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        buf_q[i] <= '0;
        cnt_q[i] <= INIT_CNT;
      end
      branch_q  <= '0;
      mispred_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENT; i++) begin
        buf_q[i] <= buf_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      branch_q  <= branch_d;
      mispred_q <= mispred_d;
    end
  end

  assign branch_count     = branch_q;
  assign mispredict_count = mispred_q;

endmodule
